vscale_wb_arbiter: RTL

Two-master, one-slave Wishbone classic arbiter that shares the single system memory/peripheral bus in the vscale generic system between the core's instruction-fetch port (master 0) and data port (master 1). Grants are round-robin and held for a whole bus cycle (`cyc` asserted). A bus-timeout watchdog terminates stalled accesses with `err` so a missing slave cannot hang simulation or silicon. It sits between `vscale` and the Wishbone interconnect inside `vscale_top`.

---
 rtl/vscale_wb_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/vscale_wb_arbiter.sv
// vscale_wb_arbiter: round-robin two-master Wishbone classic arbiter with bus-lock and timeout watchdog
module vscale_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_nxt;
  logic last, last_nxt;
  logic [15:0] wd;
  logic g0, g1, wd_fire;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  // watchdog saturates so a disabled timeout can never alias back onto a small count
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) wd <= '0;
    else wd <= (!s_stb_o || s_ack_i || s_err_i) ? '0 : (wd == 16'hffff) ? wd : wd + 16'd1;
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: state_nxt = (m0_cyc_i && m1_cyc_i) ? (last ? G0 : G1) : m0_cyc_i ? G0 : m1_cyc_i ? G1 : IDLE;
      G0: if (!m0_cyc_i) begin
        state_nxt = m1_cyc_i ? G1 : IDLE;
        last_nxt  = 1'b0;
      end
      G1: if (!m1_cyc_i) begin
        state_nxt = m0_cyc_i ? G0 : IDLE;
        last_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    g0       = state == G0;
    g1       = state == G1;
    wd_fire  = (TIMEOUT != 0) && (wd == 16'(TIMEOUT)) && !s_ack_i && !s_err_i;
    grant_o  = {g1, g0};
    s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    s_we_o   = (g0 && m0_we_i) || (g1 && m1_we_i);
    s_cyc_o  = (g0 && m0_cyc_i) || (g1 && m1_cyc_i);
    s_stb_o  = ((g0 && m0_stb_i) || (g1 && m1_stb_i)) && !wd_fire;
    m0_ack_o = s_ack_i && g0;
    m1_ack_o = s_ack_i && g1;
    m0_err_o = (s_err_i || wd_fire) && g0;
    m1_err_o = (s_err_i || wd_fire) && g1;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
  end
endmodule
